// File: rtl/fft_pkg.sv
// Constants shared between the FFT control unit and its output consumers.
package fft_pkg;
  localparam int FFT_N     = 1024;
  localparam int BIN_W     = $clog2(FFT_N);
  localparam int PWR_W     = 65;
  localparam int OUT_W_DEF = 32;
endpackage

// File: rtl/fft_result_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module fft_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_wr, do_rd;

  assign valid_o   = count_q != '0;
  assign full_o    = count_q == (AW+1)'(DEPTH);
  assign do_rd     = rd_en_i && valid_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/fft_power_unloader.sv
// Captures FFT output bins, computes scaled/saturated |X|^2 and queues {power, bin}.
module fft_power_unloader
  import fft_pkg::*;
#(
  parameter int N          = FFT_N,
  parameter int OUT_WIDTH  = OUT_W_DEF,
  parameter int SHIFT      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_ready_i,
  input  logic                 fft_done_i,
  input  logic [31:0]          x0_re_i,
  input  logic [31:0]          x0_im_i,
  output logic                 dl_busy_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic [$clog2(N)-1:0] m_bin_o,
  output logic                 m_last_o,
  output logic                 overflow_o,
  output logic                 frame_err_o
);
  localparam int BW = $clog2(N);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:1]           vld_q;
  logic signed [31:0]   re1_q, im1_q;
  logic signed [63:0]   pre2_q, pim2_q;
  logic [OUT_WIDTH-1:0] pwr3_q, pwr_d;
  logic [BW-1:0]        tag1_q, tag2_q, tag3_q;
  logic [BW-1:0]        bin_q, bin_inc, bin_d;
  logic [PWR_W-1:0]     sum, shf;
  logic                 ferr_q, ferr_d, ovf_q, busy_q;
  logic                 fifo_full, rd_fire;
  logic [CW-1:0]        fifo_cnt;
  logic [OUT_WIDTH+BW-1:0] rd_word;

  // A done pulse on the N-th bin wraps the counter to 0 first, so it is not an error.
  always_comb begin
    bin_inc = bin_q;
    if (fft_ready_i) bin_inc = (bin_q == BW'(N-1)) ? '0 : bin_q + BW'(1);
    bin_d  = bin_inc;
    ferr_d = ferr_q;
    if (fft_done_i && bin_inc != '0) begin
      bin_d  = '0;
      ferr_d = 1'b1;
    end
  end

  always_comb begin
    sum   = {1'b0, pre2_q} + {1'b0, pim2_q};
    shf   = sum >> SHIFT;
    pwr_d = ((shf >> OUT_WIDTH) != '0) ? '1 : shf[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      re1_q  <= '0;
      im1_q  <= '0;
      tag1_q <= '0;
      pre2_q <= '0;
      pim2_q <= '0;
      tag2_q <= '0;
      pwr3_q <= '0;
      tag3_q <= '0;
      bin_q  <= '0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= {vld_q[2:1], fft_ready_i};
      re1_q  <= x0_re_i;
      im1_q  <= x0_im_i;
      tag1_q <= bin_q;
      pre2_q <= 64'(re1_q) * 64'(re1_q);
      pim2_q <= 64'(im1_q) * 64'(im1_q);
      tag2_q <= tag1_q;
      pwr3_q <= pwr_d;
      tag3_q <= tag2_q;
      bin_q  <= bin_d;
      ferr_q <= ferr_d;
      if (vld_q[3] && fifo_full && !rd_fire) ovf_q <= 1'b1;
      // Margin of 6 absorbs the 3 pipe stages, this register and the FFT's reaction.
      busy_q <= fifo_cnt >= CW'(FIFO_DEPTH - 6);
    end
  end

  fft_result_fifo #(
    .W     (OUT_WIDTH + BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (vld_q[3]),
    .wr_data_i ({pwr3_q, tag3_q}),
    .rd_en_i   (m_ready_i),
    .rd_data_o (rd_word),
    .valid_o   (m_valid_o),
    .full_o    (fifo_full),
    .count_o   (fifo_cnt)
  );

  assign rd_fire     = m_valid_o && m_ready_i;
  assign m_data_o    = rd_word[OUT_WIDTH+BW-1:BW];
  assign m_bin_o     = rd_word[BW-1:0];
  assign m_last_o    = m_valid_o && (m_bin_o == BW'(N-1));
  assign dl_busy_o   = busy_q;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;
endmodule

// File: tb/tb_fft_power_unloader.sv
// Bench for fft_power_unloader: vector table, scoreboard model and corner sequences.
module tb_fft_power_unloader;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst, fft_ready, fft_done, m_ready;
  logic signed [31:0] x_re, x_im;
  logic busy_a, mv_a, ml_a, ovf_a, fe_a;
  logic busy_b, mv_b, ml_b, ovf_b, fe_b;
  logic [31:0] md_a, md_b;
  logic [3:0]  mb_a, mb_b;

  always #5 clk = ~clk;

  fft_power_unloader #(.N(N), .OUT_WIDTH(32), .SHIFT(0), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .fft_ready_i(fft_ready), .fft_done_i(fft_done),
    .x0_re_i(x_re), .x0_im_i(x_im), .dl_busy_o(busy_a), .m_valid_o(mv_a),
    .m_ready_i(m_ready), .m_data_o(md_a), .m_bin_o(mb_a), .m_last_o(ml_a),
    .overflow_o(ovf_a), .frame_err_o(fe_a));

  fft_power_unloader #(.N(N), .OUT_WIDTH(32), .SHIFT(32), .FIFO_DEPTH(16)) dut32 (
    .clk(clk), .rst(rst), .fft_ready_i(fft_ready), .fft_done_i(fft_done),
    .x0_re_i(x_re), .x0_im_i(x_im), .dl_busy_o(busy_b), .m_valid_o(mv_b),
    .m_ready_i(m_ready), .m_data_o(md_b), .m_bin_o(mb_b), .m_last_o(ml_b),
    .overflow_o(ovf_b), .frame_err_o(fe_b));

  typedef struct {logic [31:0] d0; logic [31:0] d32; logic [3:0] bin;} exp_t;
  typedef struct {logic signed [31:0] re; logic signed [31:0] im;
                  logic [31:0] e0; logic [31:0] e32;} vec_t;

  exp_t q[$];
  int   nchk = 0, nerr = 0;
  int   mbin = 0;
  bit   exp_fe = 0, sb_en = 1, busy_seen = 0;
  bit   hold_v = 0;
  logic [35:0] hold_val;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pwr(input logic signed [31:0] re, input logic signed [31:0] im,
                                      input int sh);
    longint a, b;
    logic [64:0] s;
    a = longint'(re) * longint'(re);
    b = longint'(im) * longint'(im);
    s = 65'(a) + 65'(b);
    s = s >> sh;
    if ((s >> 32) != 0) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    if (busy_a) busy_seen = 1;
  endtask

  task automatic send(input logic signed [31:0] re, input logic signed [31:0] im,
                      input bit v, input bit done);
    fft_ready = v; fft_done = done; x_re = re; x_im = im;
    if (v) begin
      q.push_back('{pwr(re, im, 0), pwr(re, im, 32), 4'(mbin)});
      mbin = (mbin + 1) % N;
    end
    if (done && mbin != 0) begin
      exp_fe = 1;
      mbin = 0;
    end
    tick;
    fft_ready = 0; fft_done = 0;
  endtask

  task automatic do_reset;
    rst = 1; fft_ready = 0; fft_done = 0; x_re = 0; x_im = 0;
    tick; tick;
    q.delete(); mbin = 0; exp_fe = 0; busy_seen = 0;
    rst = 0;
  endtask

  // Scoreboard: every transferred word must match the model, and a stalled word must hold.
  always @(negedge clk) begin
    if (rst || !sb_en) hold_v = 0;
    else begin
      if (hold_v) chk("hold", {mv_a, md_a, mb_a}, {1'b1, hold_val});
      if (mv_a && m_ready) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_word: got bin %0d data %0h expected none", mb_a, md_a);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", md_a, e.d0);
          chk("sb_data32", md_b, e.d32);
          chk("sb_bin", mb_a, e.bin);
          chk("sb_last", ml_a, e.bin == 4'(N-1));
        end
      end
      hold_v   = mv_a && !m_ready;
      hold_val = {md_a, mb_a};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tv[7];
    int sent, cnt;
    bit prevb, v;
    tv[0] = '{32'sd3, -32'sd4, 32'd25, 32'd0};
    tv[1] = '{32'sh8000_0000, 32'sh8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tv[2] = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};
    tv[3] = '{32'sd65535, 32'sd0, 32'hFFFE_0001, 32'd0};
    tv[4] = '{32'sd65536, 32'sd0, 32'hFFFF_FFFF, 32'd1};
    tv[5] = '{32'sd1, 32'sd1, 32'd2, 32'd0};
    tv[6] = '{-32'sd7, 32'sd0, 32'd49, 32'd0};

    m_ready = 1;
    do_reset;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", mv_a, 0);
    chk("rst_data", md_a, 0);
    chk("rst_bin", mb_a, 0);
    chk("rst_last", ml_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_ferr", fe_a, 0);

    // Single samples: latency, power, saturation under both shifts.
    for (int i = 0; i < 7; i++) begin
      send(tv[i].re, tv[i].im, 1, 0);
      tick; tick;
      chk("lat_early", mv_a, 0);
      tick;
      chk("lat_valid", mv_a, 1);
      chk("vec_data", md_a, tv[i].e0);
      chk("vec_data32", md_b, tv[i].e32);
      chk("vec_bin", mb_a, 4'(i));
      tick;
      chk("vec_drained", mv_a, 0);
    end

    // Full frame back to back.
    do_reset;
    for (int b = 0; b < N; b++) send(b, 0, 1, 0);
    repeat (6) tick;
    chk("frame_all_out", q.size(), 0);
    chk("frame_no_busy", busy_seen, 0);

    // Random-valued stream with random ready gaps.
    do_reset;
    for (int i = 0; i < 200; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      send($urandom, $urandom, !busy_a && ($urandom_range(0, 1) == 1), 0);
    end
    m_ready = 1;
    repeat (20) tick;
    chk("rand_all_out", q.size(), 0);
    chk("rand_no_ovf", ovf_a, 0);

    // Backpressure with an FFT that obeys dl_busy_o.
    do_reset;
    m_ready = 0; sent = 0; prevb = 0;
    for (int c = 0; c < 30; c++) begin
      v = (sent < 40) && !prevb;
      prevb = busy_a;
      send(sent, -sent, v, 0);
      if (v) sent++;
    end
    chk("bp_busy_rose", busy_seen, 1);
    chk("bp_no_ovf", ovf_a, 0);
    m_ready = 1;
    for (int c = 0; c < 300 && (sent < 40 || q.size() > 0); c++) begin
      v = (sent < 40) && !prevb;
      prevb = busy_a;
      send(sent, -sent, v, 0);
      if (v) sent++;
    end
    chk("bp_all_sent", sent, 40);
    chk("bp_all_out", q.size(), 0);
    chk("bp_busy_fell", busy_a, 0);
    chk("bp_no_ovf_end", ovf_a, 0);

    // FFT ignoring dl_busy_o: overflow, exactly DEPTH words kept.
    do_reset;
    sb_en = 0; m_ready = 0;
    for (int i = 0; i < 25; i++) send(i, 0, 1, 0);
    repeat (5) tick;
    chk("ovf_set", ovf_a, 1);
    m_ready = 1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (mv_a) cnt++;
      tick;
    end
    chk("ovf_count", cnt, 16);
    chk("ovf_sticky", ovf_a, 1);

    // Early done pulse.
    do_reset;
    sb_en = 1;
    for (int i = 0; i < 5; i++) send(i, 1, 1, 0);
    send(0, 0, 0, 1);
    chk("ferr_early", fe_a, exp_fe);
    send(9, 0, 1, 0);
    repeat (6) tick;
    chk("ferr_drained", q.size(), 0);
    chk("ferr_sticky", fe_a, 1);

    // Done coinciding with bin N-1.
    do_reset;
    for (int i = 0; i < N - 1; i++) send(i, 0, 1, 0);
    send(2, 2, 1, 1);
    chk("ferr_on_last", fe_a, exp_fe);
    send(5, 0, 1, 0);
    repeat (6) tick;
    chk("last_drained", q.size(), 0);

    // Reset with 2 bins in the pipe and 5 in the FIFO.
    do_reset;
    m_ready = 0;
    for (int i = 0; i < 7; i++) send(i + 1, 0, 1, 0);
    tick;
    rst = 1;
    tick;
    chk("mid_busy", busy_a, 0);
    chk("mid_valid", mv_a, 0);
    chk("mid_data", md_a, 0);
    chk("mid_bin", mb_a, 0);
    chk("mid_last", ml_a, 0);
    chk("mid_ovf", ovf_a, 0);
    chk("mid_ferr", fe_a, 0);
    q.delete(); mbin = 0; exp_fe = 0;
    rst = 0; m_ready = 1; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (mv_a) cnt++;
      tick;
    end
    chk("mid_no_stale", cnt, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fft_power_unloader.md
# fft_power_unloader

Downstream consumer of the FFT core's output port. It captures the FFT result stream one complex bin per cycle and computes the power of each bin, re² + im², with scaling and saturation. Results are buffered in a small FIFO together with the bin index and presented on a valid/ready stream to the data logger or DMA. When the FIFO nears capacity it raises `dl_busy_o` to throttle the FFT, and it flags lost samples and malformed frames.

## Interface
Parameters:
- `N`, 1024: FFT length, power of two; bins per frame.
- `OUT_WIDTH`, 32: width of the power result.
- `SHIFT`, 32: right shift applied to the 65-bit power sum before saturation.
- `FIFO_DEPTH`, 16: result FIFO entries, power of two, ≥ 8.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `fft_ready_i`  in  1: `x0_re_i`/`x0_im_i` carry a valid bin this cycle.
- `fft_done_i`  in  1: one-cycle pulse marking the end of an FFT unload.
- `x0_re_i`  in  32: real part, signed two's complement.
- `x0_im_i`  in  32: imaginary part, signed two's complement.
- `dl_busy_o`  out  1: throttle to the FFT; the FFT stops presenting bins on the cycle after it sees this high.
- `m_valid_o`  out  1: result word available.
- `m_ready_i`  in  1: consumer accepts the word.
- `m_data_o`  out  OUT_WIDTH: scaled power.
- `m_bin_o`  out  clog2(N): bin index of `m_data_o`.
- `m_last_o`  out  1: high when `m_bin_o` = N-1.
- `overflow_o`  out  1: sticky; a result was dropped because the FIFO was full.
- `frame_err_o`  out  1: sticky; `fft_done_i` arrived before N bins were seen.

## Operation
- **Reset values.** All outputs are 0 in reset: `dl_busy_o`, `m_valid_o`, `m_data_o`, `m_bin_o`, `m_last_o`, `overflow_o`, `frame_err_o`. Reset empties the FIFO and clears the pipeline, the bin counter and both sticky flags. Reset asserted mid-frame discards everything in flight; no word is emitted afterwards until new input arrives.
- **Bin counter.** `bin_cnt` counts 0..N-1. It advances on every cycle with `fft_ready_i` = 1 and wraps from N-1 to 0. Each accepted sample is tagged with the current `bin_cnt`.
- **Pipeline**, 3 stages:
  - S1 registers re, im, tag and valid.
  - S2 computes the signed products re·re and im·im, 64 bits each.
  - S3 computes the unsigned 65-bit sum, shifts it right by `SHIFT`, and saturates to 2^OUT_WIDTH − 1 if any bit above `OUT_WIDTH` is set. S3 output is written to the FIFO.
- **FIFO.** First-word-fall-through. Each entry holds {data, bin}; `m_last_o` is derived from the bin. A word transfers when `m_valid_o` and `m_ready_i` are both high. A simultaneous read and write leaves the count unchanged.
- **Full FIFO.** A write arriving at a full FIFO with no read in the same cycle is dropped and `overflow_o` is set. Data already in the FIFO is never overwritten.
- **dl_busy_o.** Registered; high when fifo_count ≥ FIFO_DEPTH − 6. The margin covers 3 pipeline stages, the register stage and the FFT's 1-cycle reaction.
- **fft_done_i.**
  - If `bin_cnt` ≠ 0 after this cycle's increment, set `frame_err_o` and force `bin_cnt` to 0.
  - If `fft_done_i` coincides with the N-th bin, the bin is counted first and the counter wraps to 0 with no error.
  - In-flight results still drain normally.
- Sticky flags clear only on `rst`.

## Timing
- **Latency.** A bin sampled at edge k is written to the FIFO at edge k+3. `m_valid_o` is high in the cycle after edge k+3 when the FIFO was empty.
- **Throughput.** One bin per cycle sustained while `m_ready_i` = 1; `dl_busy_o` never asserts in that case.
- **Output hold.** `m_data_o`, `m_bin_o` and `m_last_o` are stable while `m_valid_o` = 1 and `m_ready_i` = 0.
- **dl_busy_o update.** Updates one cycle after the fifo_count change that crosses the threshold, in both directions.

## Structure
- Shared package `fft_pkg` holds:
  - the `N` and `clog2(N)` bin-index width constants, shared with the FFT control unit;
  - the power-sum width constant (65);
  - the `OUT_WIDTH` default.
- Sub-module `fft_result_fifo`: a parameterised synchronous FWFT FIFO with count output. The power pipeline, bin counter and flags stay in the top level.

## Test plan
- **Single sample.** Reset, then one sample re=3, im=−4 with `SHIFT`=0 → `m_valid_o` after 3 edges; `m_data_o`=25, `m_bin_o`=0, `m_last_o`=0.
- **Full frame.** N=16, `m_ready_i`=1, 16 back-to-back bins with re=bin, im=0, `SHIFT`=0 → outputs 0,1,4,…,225 in order; `m_last_o` only on bin 15; `dl_busy_o` stays 0.
- **Saturation.** re=im=−2^31 with `SHIFT`=32 → sum 2^63 shifted to 2^31, not saturated. The same input with `SHIFT`=0 → `m_data_o`=0xFFFF_FFFF.
- **Backpressure.** `m_ready_i`=0 while an FFT model obeying `dl_busy_o` streams bins → `dl_busy_o` rises once count ≥ 10; `overflow_o` stays 0. Release `m_ready_i` → all bins arrive in order with none missing. Repeat with a model ignoring `dl_busy_o` → `overflow_o`=1 and the FIFO holds exactly 16 words.
- **Frame errors.** `fft_done_i` pulse after 5 bins → `frame_err_o`=1 and the next bin is tagged 0. Separately, `fft_done_i` in the same cycle as bin N-1 → `frame_err_o` stays 0.
- **Reset mid-frame.** `rst` with 2 bins in the pipeline and 5 in the FIFO → next cycle all outputs are 0 and no stale word appears afterwards.
